// File: rtl/cp0_exc_ctrl.sv
// CP0 exception/interrupt sequencer and Count/Compare timer.
// Prioritises commit-point exceptions against interrupts, runs flush/redirect, owns the timer.
module cp0_exc_ctrl #(
  parameter int unsigned FLUSH_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ex_valid,
  input  logic        ex_bd,
  input  logic [31:0] ex_pc,
  input  logic [7:0]  exc_flags,
  input  logic        status_ie,
  input  logic        status_exl,
  input  logic [7:0]  status_im,
  input  logic [7:0]  cause_ip,
  input  logic        mtc0_we,
  input  logic [5:0]  cp0_addr,
  input  logic [31:0] mtc0_data,
  output logic        exception,
  output logic [4:0]  exc_code,
  output logic        bd,
  output logic [31:0] epc,
  output logic        eret_flush,
  output logic        flush,
  output logic        redirect_valid,
  output logic        redirect_sel,
  output logic [31:0] count,
  output logic        equal
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_FLUSH = 2'd1;
  localparam logic [1:0] ST_REDIR = 2'd2;

  localparam logic [5:0] REG_COUNT   = 6'd9;
  localparam logic [5:0] REG_COMPARE = 6'd11;

  localparam logic [2:0] FLUSH_INIT = 3'(FLUSH_CYCLES - 32'd1);

  // Returns {is_exception, exc_code}; is_exception=0 means only ERET remains.
  function automatic logic [5:0] prioritise(input logic int_pend, input logic [7:0] flags);
    logic [5:0] res;
    if (int_pend) begin
      res = {1'b1, 5'h00};
    end else if (flags[0]) begin
      res = {1'b1, 5'h04};
    end else if (flags[1]) begin
      res = {1'b1, 5'h0a};
    end else if (flags[2]) begin
      res = {1'b1, 5'h0c};
    end else if (flags[3]) begin
      res = {1'b1, 5'h08};
    end else if (flags[4]) begin
      res = {1'b1, 5'h09};
    end else if (flags[5]) begin
      res = {1'b1, 5'h04};
    end else if (flags[6]) begin
      res = {1'b1, 5'h05};
    end else begin
      res = {1'b0, 5'h00};
    end
    return res;
  endfunction

  logic [1:0]  state_r;
  logic [1:0]  state_nxt_s;
  logic [2:0]  flush_cnt_r;
  logic [2:0]  flush_cnt_nxt_s;
  logic        int_pend_s;
  logic        take_s;
  logic [5:0]  prio_s;
  logic        take_exc_s;
  logic [4:0]  take_code_s;

  logic        exception_r;
  logic [4:0]  exc_code_r;
  logic        bd_r;
  logic [31:0] epc_r;
  logic        eret_flush_r;
  logic        flush_r;
  logic        redirect_valid_r;
  logic        redirect_sel_r;

  logic [31:0] count_r;
  logic [31:0] compare_r;
  logic        tick_r;
  logic        inc_d_r;
  logic        equal_r;
  logic        count_load_s;
  logic        compare_load_s;
  logic        inc_s;

  assign int_pend_s  = status_ie & ~status_exl & (|(status_im & cause_ip));
  assign take_s      = (state_r == ST_IDLE) & ex_valid & (int_pend_s | (|exc_flags));
  assign prio_s      = prioritise(int_pend_s, exc_flags);
  assign take_exc_s  = prio_s[5];
  assign take_code_s = prio_s[4:0];

  // Sequencer next-state: IDLE -> FLUSH (FLUSH_CYCLES cycles) -> REDIR (one cycle) -> IDLE.
  always_comb begin
    state_nxt_s     = state_r;
    flush_cnt_nxt_s = flush_cnt_r;
    case (state_r)
      ST_IDLE: begin
        if (take_s) begin
          state_nxt_s     = ST_FLUSH;
          flush_cnt_nxt_s = FLUSH_INIT;
        end else begin
          state_nxt_s     = ST_IDLE;
          flush_cnt_nxt_s = 3'd0;
        end
      end
      ST_FLUSH: begin
        if (flush_cnt_r == 3'd0) begin
          state_nxt_s     = ST_REDIR;
          flush_cnt_nxt_s = 3'd0;
        end else begin
          state_nxt_s     = ST_FLUSH;
          flush_cnt_nxt_s = flush_cnt_r - 3'd1;
        end
      end
      ST_REDIR: begin
        state_nxt_s     = ST_IDLE;
        flush_cnt_nxt_s = 3'd0;
      end
      default: begin
        state_nxt_s     = ST_IDLE;
        flush_cnt_nxt_s = 3'd0;
      end
    endcase
  end

  // Sequencer state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= ST_IDLE;
      flush_cnt_r <= 3'd0;
    end else begin
      state_r     <= state_nxt_s;
      flush_cnt_r <= flush_cnt_nxt_s;
    end
  end

  // Sequencer outputs, registered from next-state so they align with the state they describe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exception_r      <= 1'b0;
      eret_flush_r     <= 1'b0;
      flush_r          <= 1'b0;
      redirect_valid_r <= 1'b0;
      redirect_sel_r   <= 1'b0;
      exc_code_r       <= 5'd0;
      bd_r             <= 1'b0;
      epc_r            <= 32'd0;
    end else begin
      exception_r      <= take_s & take_exc_s;
      eret_flush_r     <= take_s & ~take_exc_s;
      flush_r          <= (state_nxt_s == ST_FLUSH);
      redirect_valid_r <= (state_nxt_s == ST_REDIR);
      if (take_s) begin
        redirect_sel_r <= ~take_exc_s;
        exc_code_r     <= take_exc_s ? take_code_s : 5'd0;
        bd_r           <= ex_bd;
        epc_r          <= ex_bd ? (ex_pc - 32'd4) : ex_pc;
      end else begin
        redirect_sel_r <= redirect_sel_r;
        exc_code_r     <= exc_code_r;
        bd_r           <= bd_r;
        epc_r          <= epc_r;
      end
    end
  end

  assign count_load_s   = mtc0_we & (cp0_addr == REG_COUNT);
  assign compare_load_s = mtc0_we & (cp0_addr == REG_COMPARE);
  // A Count load pre-empts the increment, so it can never be the source of an equal pulse.
  assign inc_s          = tick_r & ~count_load_s;

  // Count/Compare timer; Count advances every second cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_r   <= 32'd0;
      compare_r <= 32'd0;
      tick_r    <= 1'b0;
      inc_d_r   <= 1'b0;
      equal_r   <= 1'b0;
    end else begin
      if (count_load_s) begin
        count_r <= mtc0_data;
        tick_r  <= 1'b0;
      end else begin
        count_r <= inc_s ? (count_r + 32'd1) : count_r;
        tick_r  <= ~tick_r;
      end
      if (compare_load_s) begin
        compare_r <= mtc0_data;
      end else begin
        compare_r <= compare_r;
      end
      inc_d_r <= inc_s;
      equal_r <= inc_d_r & (count_r == compare_r);
    end
  end

  assign exception      = exception_r;
  assign exc_code       = exc_code_r;
  assign bd             = bd_r;
  assign epc            = epc_r;
  assign eret_flush     = eret_flush_r;
  assign flush          = flush_r;
  assign redirect_valid = redirect_valid_r;
  assign redirect_sel   = redirect_sel_r;
  assign count          = count_r;
  assign equal          = equal_r;

endmodule

// File: tb/tb_cp0_exc_ctrl.sv
// Self-checking bench for cp0_exc_ctrl: directed scenarios plus randomized takes
// against a priority/timing reference model.
module tb_cp0_exc_ctrl;

  localparam int F = 2;

  logic        clk;
  logic        rst_n;
  logic        ex_valid;
  logic        ex_bd;
  logic [31:0] ex_pc;
  logic [7:0]  exc_flags;
  logic        status_ie;
  logic        status_exl;
  logic [7:0]  status_im;
  logic [7:0]  cause_ip;
  logic        mtc0_we;
  logic [5:0]  cp0_addr;
  logic [31:0] mtc0_data;
  logic        exception;
  logic [4:0]  exc_code;
  logic        bd;
  logic [31:0] epc;
  logic        eret_flush;
  logic        flush;
  logic        redirect_valid;
  logic        redirect_sel;
  logic [31:0] count;
  logic        equal;

  int checks = 0;
  int errors = 0;

  cp0_exc_ctrl #(.FLUSH_CYCLES(F)) dut (
    .clk(clk), .rst_n(rst_n), .ex_valid(ex_valid), .ex_bd(ex_bd), .ex_pc(ex_pc),
    .exc_flags(exc_flags), .status_ie(status_ie), .status_exl(status_exl),
    .status_im(status_im), .cause_ip(cause_ip), .mtc0_we(mtc0_we), .cp0_addr(cp0_addr),
    .mtc0_data(mtc0_data), .exception(exception), .exc_code(exc_code), .bd(bd), .epc(epc),
    .eret_flush(eret_flush), .flush(flush), .redirect_valid(redirect_valid),
    .redirect_sel(redirect_sel), .count(count), .equal(equal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: which event (if any) the committing instruction raises.
  function automatic void ref_model(input logic [7:0] f, input logic ie, input logic exl,
                                    input logic [7:0] im, input logic [7:0] ip,
                                    output logic take, output logic is_exc, output logic [4:0] code);
    logic [4:0] pri_code [7];
    logic       pend;
    pri_code = '{5'h04, 5'h0a, 5'h0c, 5'h08, 5'h09, 5'h04, 5'h05};
    pend = 1'b0;
    for (int i = 0; i < 8; i++) if (im[i] && ip[i]) pend = 1'b1;
    pend   = pend && ie && !exl;
    take   = pend || (f != 8'd0);
    is_exc = 1'b0;
    code   = 5'h00;
    if (pend) begin
      is_exc = 1'b1;
    end else begin
      for (int i = 0; i < 7; i++) begin
        if (!is_exc && f[i]) begin
          is_exc = 1'b1;
          code   = pri_code[i];
        end
      end
    end
  endfunction

  task automatic idle_inputs();
    ex_valid = 1'b0; ex_bd = 1'b0; ex_pc = 32'd0; exc_flags = 8'd0;
    status_ie = 1'b0; status_exl = 1'b0; status_im = 8'd0; cause_ip = 8'd0;
    mtc0_we = 1'b0; cp0_addr = 6'd0; mtc0_data = 32'd0;
  endtask

  // Presents one commit-point instruction and follows the whole sequence it should cause.
  task automatic do_event(input string tag, input logic [7:0] f, input logic valid,
                          input logic bdi, input logic [31:0] pc, input logic ie,
                          input logic exl, input logic [7:0] im, input logic [7:0] ip,
                          input logic spam);
    logic take, is_exc;
    logic [4:0] code;
    logic [31:0] exp_epc;
    int ncyc;
    ref_model(f, ie, exl, im, ip, take, is_exc, code);
    take    = take && valid;
    exp_epc = bdi ? pc - 32'd4 : pc;
    ex_valid = valid; exc_flags = f; ex_bd = bdi; ex_pc = pc;
    status_ie = ie; status_exl = exl; status_im = im; cause_ip = ip;
    ncyc = take ? F + 3 : 2;
    for (int c = 1; c <= ncyc; c++) begin
      @(posedge clk); #1;
      if ((!spam && c == 1) || c == F + 2) begin
        ex_valid = 1'b0; exc_flags = 8'd0;
      end
      checks++;
      if (exception !== (take && is_exc && c == 1)) begin
        errors++; $display("FAIL %s exception c=%0d: got %b expected %b", tag, c, exception, take && is_exc && c == 1);
      end
      checks++;
      if (eret_flush !== (take && !is_exc && c == 1)) begin
        errors++; $display("FAIL %s eret_flush c=%0d: got %b expected %b", tag, c, eret_flush, take && !is_exc && c == 1);
      end
      checks++;
      if (flush !== (take && c <= F)) begin
        errors++; $display("FAIL %s flush c=%0d: got %b expected %b", tag, c, flush, take && c <= F);
      end
      checks++;
      if (redirect_valid !== (take && c == F + 1)) begin
        errors++; $display("FAIL %s redirect_valid c=%0d: got %b expected %b", tag, c, redirect_valid, take && c == F + 1);
      end
      if (take && is_exc && c == 1) begin
        checks++;
        if (exc_code !== code || bd !== bdi || epc !== exp_epc) begin
          errors++; $display("FAIL %s code/bd/epc: got %h/%b/%h expected %h/%b/%h", tag, exc_code, bd, epc, code, bdi, exp_epc);
        end
      end
      if (take && c == F + 1) begin
        checks++;
        if (redirect_sel !== !is_exc) begin
          errors++; $display("FAIL %s redirect_sel: got %b expected %b", tag, redirect_sel, !is_exc);
        end
      end
    end
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({exception, eret_flush, flush, redirect_valid, redirect_sel, exc_code, bd, epc, count, equal} !== 75'd0) begin
      errors++; $display("FAIL reset outputs: got exc=%b eret=%b flush=%b rv=%b sel=%b code=%h bd=%b epc=%h count=%h equal=%b expected all zero",
                         exception, eret_flush, flush, redirect_valid, redirect_sel, exc_code, bd, epc, count, equal);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_ov();
    do_event("ov", 8'h04, 1'b1, 1'b0, 32'hBFC00100, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
  endtask

  task automatic test_int_priority();
    do_event("int_over_ri", 8'h0A, 1'b1, 1'b1, 32'h80000014, 1'b1, 1'b0, 8'h04, 8'h04, 1'b0);
    do_event("ri_exl", 8'h0A, 1'b1, 1'b1, 32'h80000014, 1'b1, 1'b1, 8'h04, 8'h04, 1'b0);
  endtask

  task automatic test_eret();
    do_event("eret", 8'h80, 1'b1, 1'b0, 32'h80001000, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
    do_event("eret_sys", 8'h88, 1'b1, 1'b0, 32'h80001004, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
    do_event("no_valid", 8'h04, 1'b0, 1'b0, 32'h80001008, 1'b1, 1'b0, 8'hFF, 8'hFF, 1'b0);
  endtask

  task automatic test_back_to_back();
    do_event("b2b", 8'h04, 1'b1, 1'b0, 32'h80002000, 1'b0, 1'b0, 8'h00, 8'h00, 1'b1);
  endtask

  task automatic test_random();
    logic [7:0] f;
    for (int n = 0; n < 40; n++) begin
      case ($urandom_range(0, 3))
        0: f = 8'd0;
        1: f = 8'd1 << $urandom_range(0, 7);
        2: f = 8'($urandom);
        default: f = 8'h80 | (8'd1 << $urandom_range(0, 6));
      endcase
      do_event("random", f, ($urandom % 4) != 0, 1'($urandom), {$urandom_range(0, 32'h3FFFFFFF), 2'b00},
               1'($urandom), 1'($urandom), 8'($urandom), 8'($urandom), 1'($urandom));
    end
  endtask

  task automatic mtc0(input logic [5:0] addr, input logic [31:0] data);
    mtc0_we = 1'b1; cp0_addr = addr; mtc0_data = data;
    @(posedge clk); #1;
    mtc0_we = 1'b0;
  endtask

  // After a Count load at cycle L, cycle L+k shows data + (k-1)/2; equal follows one cycle after a matching increment.
  task automatic timer_case(input string tag, input logic [31:0] cmp, input logic [31:0] data, input int ncyc);
    logic [31:0] exp_cnt;
    logic exp_eq;
    mtc0(6'd11, cmp);
    mtc0(6'd9, data);
    for (int k = 1; k <= ncyc; k++) begin
      exp_cnt = data + 32'((k - 1) / 2);
      checks++;
      if (count !== exp_cnt) begin
        errors++; $display("FAIL %s count k=%0d: got %h expected %h", tag, k, count, exp_cnt);
      end
      if (k >= 2) begin
        exp_eq = (k >= 4) && (k % 2 == 0) && ((data + 32'((k - 2) / 2)) == cmp);
        checks++;
        if (equal !== exp_eq) begin
          errors++; $display("FAIL %s equal k=%0d: got %b expected %b", tag, k, equal, exp_eq);
        end
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_timer();
    logic [31:0] d;
    timer_case("timer_cmp3", 32'd3, 32'd0, 12);
    timer_case("timer_load_eq", 32'd3, 32'd3, 8);
    timer_case("timer_wrap", 32'd0, 32'hFFFFFFFF, 8);
    d = $urandom;
    timer_case("timer_rand", d + 32'($urandom_range(1, 4)), d, 14);
  endtask

  task automatic test_reset_mid();
    ex_valid = 1'b1; exc_flags = 8'h04; ex_pc = 32'h80003000; ex_bd = 1'b0;
    @(posedge clk); #1;
    ex_valid = 1'b0; exc_flags = 8'd0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({exception, eret_flush, flush, redirect_valid, redirect_sel, exc_code, bd, epc, count, equal} !== 75'd0) begin
      errors++; $display("FAIL reset_mid async clear: got flush=%b rv=%b code=%h epc=%h count=%h expected all zero",
                         flush, redirect_valid, exc_code, epc, count);
    end
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    for (int c = 0; c < F + 3; c++) begin
      @(posedge clk); #1;
      checks++;
      if (redirect_valid !== 1'b0 || flush !== 1'b0 || exception !== 1'b0) begin
        errors++; $display("FAIL reset_mid aftermath c=%0d: got rv=%b flush=%b exc=%b expected 0/0/0", c, redirect_valid, flush, exception);
      end
    end
  endtask

  initial begin
    test_reset();
    test_ov();
    test_int_priority();
    test_eret();
    test_back_to_back();
    test_timer();
    test_random();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
